uart_core_param: RTL and testbench

Parametrised full-duplex UART core and the successor to the fixed 8N1 UART driver. Frame format is set at elaboration: data width, parity mode, stop-bit count and bit period. The receiver uses mid-bit sampling with false-start rejection. Both directions use valid/ready handshakes, and the receive side reports parity, framing and overrun errors. The block sits between a host register interface and the TX/RX pins.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_rx_frame.sv | 142 ++++++++++++++
 rtl/uart_core_param.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core.
// Holds the parity-mode and FSM state enums plus frame and parity helpers
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Number of serial bit slots in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
    int par_bits;
    if (parity_mode != 32'sd0) begin
      par_bits = 32'sd1;
    end else begin
      par_bits = 32'sd0;
    end
    return 32'sd1 + data_bits + par_bits + stop_bits;
  endfunction

  // Parity bit for a word of up to 9 bits; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input parity_mode_e mode);
    logic bit_v;
    case (mode)
      PAR_EVEN: bit_v = ^data;
      PAR_ODD:  bit_v = ~(^data);
      default:  bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// Receive framer: 2-flop synchroniser, RX FSM with mid-bit sampling and
// false-start rejection, bit counter and LSB-first shift register.
// done_o pulses for one cycle on the cycle of the stop-bit sample; data and
// error flags are valid alongside it.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam parity_mode_e  PAR_CFG  = parity_mode_e'(PARITY_MODE[1:0]);

  logic                 sync1_q, sync2_q;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 done_s;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // RX FSM, counters and shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= {BW{1'b0}};
      shreg_q <= {DATA_BITS{1'b0}};
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic: half-bit wait from the start edge, then one sample per bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_s  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = {CW{1'b0}};
          bit_d = {BW{1'b0}};
          if (sync2_q) begin
            state_d = RX_IDLE;   // glitch shorter than half a bit
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = {CW{1'b0}};
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            if (PAR_CFG == PAR_NONE) begin
              state_d = RX_STOP;
            end else begin
              state_d = RX_PARITY;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = {CW{1'b0}};
          par_d   = sync2_q;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // Only the first stop bit is sampled; going idle straight away lets a
        // start edge inside a second stop bit be caught.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = {CW{1'b0}};
          done_s  = 1'b1;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign done_o       = done_s;
  assign data_o       = shreg_q;
  assign frame_err_o  = ~sync2_q;
  assign parity_err_o = (PAR_CFG != PAR_NONE) && (par_q != parity_bit(9'(shreg_q), PAR_CFG));

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core with valid/ready host handshakes.
// Contains the TX FSM, the receive holding register (rx_valid, flags,
// overrun) and the optional loopback mux.
// Optional feature: define UART_LOOPBACK_EN to add the 'loopback' input, which
// routes the internal tx into the receiver and holds the tx pin high.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TCW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] BIT_LAST  = TCW'(CLKS_PER_BIT - 1);
  localparam logic [TCW-1:0] STOP_LAST = TCW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam parity_mode_e   PAR_CFG   = parity_mode_e'(PARITY_MODE[1:0]);
  localparam int             FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);

  if (CLKS_PER_BIT < 32'sd4 || (CLKS_PER_BIT % 32'sd2) != 32'sd0 ||
      DATA_BITS < 32'sd5 || DATA_BITS > 32'sd9 || PARITY_MODE > 32'sd2 ||
      STOP_BITS < 32'sd1 || STOP_BITS > 32'sd2 || FRAME_BITS > 32'sd13) begin : g_param_err
    $error("uart_core_param: unsupported frame configuration");
  end

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;

  // TX FSM and serial output register; tx idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= {TCW{1'b0}};
      tx_bit_q   <= {BW{1'b0}};
      tx_shreg_q <= {DATA_BITS{1'b0}};
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: each bit level is loaded into tx_q on the edge that enters its slot.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_cnt_d   = {TCW{1'b0}};
          tx_shreg_d = tx_data;
          tx_par_d   = parity_bit(9'(tx_data), PAR_CFG);
          tx_d       = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = {TCW{1'b0}};
          tx_bit_d   = {BW{1'b0}};
          tx_state_d = TX_DATA;
          tx_d       = tx_shreg_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = {TCW{1'b0}};
          if (tx_bit_q == LAST_BIT) begin
            if (PAR_CFG == PAR_NONE) begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end else begin
              tx_state_d = TX_PARITY;
              tx_d       = tx_par_q;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
            tx_d       = tx_shreg_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = {TCW{1'b0}};
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d   = {TCW{1'b0}};
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_busy  = ~tx_ready;

  // ---------------- loopback mux ----------------
  logic rx_src_s;
`ifdef UART_LOOPBACK_EN
  assign rx_src_s = loopback ? tx_q : rx;
  assign tx       = loopback ? 1'b1 : tx_q;
`else
  assign rx_src_s = rx;
  assign tx       = tx_q;
`endif

  // ---------------- receiver ----------------
  logic                 rx_done_s;
  logic [DATA_BITS-1:0] rx_word_s;
  logic                 rx_perr_s, rx_ferr_s;

  uart_rx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY_MODE (PARITY_MODE)
  ) u_rx_frame (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_src_s),
    .done_o      (rx_done_s),
    .data_o      (rx_word_s),
    .parity_err_o(rx_perr_s),
    .frame_err_o (rx_ferr_s)
  );

  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  // Receive holding register presented to the host.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= {DATA_BITS{1'b0}};
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // A completed word always wins; it flags overrun only if the old word is not consumed now.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_done_s) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_word_s;
      rx_perr_d  = rx_perr_s;
      rx_ferr_d  = rx_ferr_s;
      rx_ovr_d   = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// Self-checking bench for uart_core_param (16 clk/bit, 8 data bits, even
// parity, 1 stop bit). Expected frames and receive results come from a
// bit-list model of the frame format.
module tb_uart_core_param;

  localparam int CPB = 16;
  localparam int NB  = 11;   // start + 8 data + parity + stop

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx;
  logic       rx, rx_drv, use_wire;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rx = use_wire ? tx : rx_drv;

  uart_core_param #(
    .CLKS_PER_BIT(16),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef UART_LOOPBACK_EN
    .loopback     (1'b0),
`endif
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .tx           (tx),
    .rx           (rx),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Even parity bit: 1 when the word holds an odd number of ones.
  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  // Frame as a list of line levels in transmission order.
  function automatic logic [NB-1:0] make_frame(input logic [7:0] d, input logic flip_par, input logic stop_val);
    logic [NB-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = even_par(d) ^ flip_par;
    f[10] = stop_val;
    return f;
  endfunction

  // Handshake one word and check every bit slot on tx plus tx_ready return timing.
  task automatic send_tx_check(input logic [7:0] d);
    logic [NB-1:0] f;
    int w;
    f = make_frame(d, 1'b0, 1'b1);
    w = 0;
    while (!tx_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    check_val("tx_ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 1; n <= 177; n++) begin
      @(negedge clk);
      if (n == 1) begin
        tx_valid = 1'b0;
        check_val("tx_start_next_cycle", tx, 0);
      end
      if ((n % CPB) == 8) check_val($sformatf("tx_bit%0d_of_%02h", n / CPB, d), tx, f[n / CPB]);
      if (n == 100) check_val("tx_busy_mid", tx_busy, 1);
      if (n == 176) check_val("tx_ready_t175", tx_ready, 0);
      if (n == 177) check_val("tx_ready_t176", tx_ready, 1);
    end
  endtask

  // Drive a frame on rx; report the negedge index at which rx_valid first rose.
  task automatic drive_frame(input logic [NB-1:0] f, output int first_n);
    int k;
    k = 0;
    first_n = -1;
    for (int b = 0; b < NB; b++) begin
      rx_drv = f[b];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        k++;
        if (rx_valid && first_n < 0) first_n = k;
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    int w;
    w = 0;
    while (!rx_valid && w < 400) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "_valid"}, rx_valid, 1);
    check_val({tag, "_data"}, rx_data, d);
    check_val({tag, "_perr"}, rx_parity_err, pe);
    check_val({tag, "_ferr"}, rx_frame_err, fe);
    check_val({tag, "_ovr"}, rx_overrun, ov);
  endtask

  task automatic pulse_ready(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check_val({tag, "_valid_clr"}, rx_valid, 0);
    check_val({tag, "_ovr_clr"}, rx_overrun, 0);
    check_val({tag, "_flags_clr"}, {rx_parity_err, rx_frame_err}, 0);
  endtask

  // Idle for n cycles and require that no word is presented.
  task automatic idle_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rx_valid) seen = 1'b1;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int fv;
    logic [7:0] d;
    logic fp, sv;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    rx_drv = 1'b1; rx_ready = 1'b0; use_wire = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_tx_ready", tx_ready, 1);
    check_val("rst_tx_busy", tx_busy, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5 out on tx and back in through an external wire.
    use_wire = 1'b1;
    send_tx_check(8'hA5);
    expect_word("wire_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_val("wire_a5_held", rx_valid, 1);
    check_val("wire_a5_held_data", rx_data, 8'hA5);
    pulse_ready("wire_a5");
    use_wire = 1'b0;
    repeat (20) @(negedge clk);

    // Bad parity, then bad stop bit.
    drive_frame(make_frame(8'h3C, 1'b1, 1'b1), fv);
    check_val("perr_latency", fv, 171);
    expect_word("perr_3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    pulse_ready("perr_3c");
    repeat (20) @(negedge clk);
    drive_frame(make_frame(8'h3C, 1'b0, 1'b0), fv);
    expect_word("ferr_3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    pulse_ready("ferr_3c");
    idle_quiet("ferr_no_spurious", 40);

    // Short glitch rejected, then a clean frame.
    rx_drv = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv = 1'b1;
    idle_quiet("false_start_quiet", 40);
    drive_frame(make_frame(8'h11, 1'b0, 1'b1), fv);
    check_val("after_glitch_latency", fv, 171);
    expect_word("after_glitch_11", 8'h11, 1'b0, 1'b0, 1'b0);
    pulse_ready("after_glitch_11");
    repeat (20) @(negedge clk);

    // Overrun: two words without consuming the first.
    drive_frame(make_frame(8'h01, 1'b0, 1'b1), fv);
    expect_word("ovr_first", 8'h01, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    drive_frame(make_frame(8'h02, 1'b0, 1'b1), fv);
    expect_word("ovr_second", 8'h02, 1'b0, 1'b0, 1'b1);
    pulse_ready("ovr");
    repeat (20) @(negedge clk);

    // Reset in the middle of both frames.
    use_wire = 1'b1;
    @(negedge clk);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_tx", tx, 1);
    check_val("midrst_tx_ready", tx_ready, 1);
    check_val("midrst_rx_valid", rx_valid, 0);
    rst = 1'b0;
    idle_quiet("midrst_no_partial", 250);
    send_tx_check(8'h5A);
    expect_word("post_rst_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
    pulse_ready("post_rst_5a");

    // Random words through tx and the wire.
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_tx_check(d);
      expect_word($sformatf("rnd_wire%0d", i), d, 1'b0, 1'b0, 1'b0);
      pulse_ready($sformatf("rnd_wire%0d", i));
    end
    use_wire = 1'b0;
    repeat (20) @(negedge clk);

    // Random directly driven frames with random parity/stop corruption.
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      fp = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 3) != 0);
      drive_frame(make_frame(d, fp, sv), fv);
      check_val($sformatf("rnd_rx%0d_latency", i), fv, 171);
      expect_word($sformatf("rnd_rx%0d", i), d, fp, ~sv, 1'b0);
      pulse_ready($sformatf("rnd_rx%0d", i));
      idle_quiet($sformatf("rnd_rx%0d_quiet", i), 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
